// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with tear-free frame commits.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [1:0]  S,
    output logic [3:0]  an,
    output logic        upd_done,
    output logic        pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GRD  = PW'(GUARD);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_n;
    logic [1:0]    s_n;
    logic [15:0]   shadow;
    logic          wrap;
    logic          commit;
    logic          blank;
    logic [3:0]    an_n;

`ifdef SEG_LZ_BLANK_EN
    logic [15:0] dv_n;
`endif

    always_comb begin
        wrap    = (phase == LAST);
        phase_n = wrap ? '0 : phase + 1'b1;
        s_n     = wrap ? S + 2'd1 : S;
        commit  = wrap && (S == 2'd3) && pending;
        blank   = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        // Blanking looks at the values that will be shown next cycle.
        dv_n = commit ? shadow : {d4, d3, d2, d1};
        unique case (s_n)
            2'd3:    blank = (dv_n[15:12] == 4'h0);
            2'd2:    blank = (dv_n[15:8] == 8'h00);
            2'd1:    blank = (dv_n[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
        if (!en || (phase_n < GRD) || blank)
            an_n = 4'hF;
        else
            an_n = ~(4'b0001 << s_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            S        <= 2'd0;
            an       <= 4'hF;
            d1       <= 4'h0;
            d2       <= 4'h0;
            d3       <= 4'h0;
            d4       <= 4'h0;
            shadow   <= 16'h0;
            pending  <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            phase    <= phase_n;
            S        <= s_n;
            an       <= an_n;
            upd_done <= commit;
            if (commit) begin
                {d4, d3, d2, d1} <= shadow;
                pending          <= 1'b0;
            end
            // A load on the boundary still wins pending for the next frame.
            if (load) begin
                shadow  <= din;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl.
// REFRESH_DIV=8, GUARD=2: one frame is 32 cycles.
module tb_seg_scan_ctrl;

    localparam int DIV = 8;
    localparam int GRD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = 16'h0;
    logic [3:0]  d1, d2, d3, d4;
    logic [1:0]  S;
    logic [3:0]  an;
    logic        upd_done;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    logic [15:0] exp_d = 16'h0;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .S(S), .an(an),
        .upd_done(upd_done), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else k++;
    endtask

    function automatic logic [3:0] exp_an(input int kk, input logic [15:0] dv,
                                          input logic e);
        int ph;
        int s;
        ph = kk % DIV;
        s  = (kk / DIV) % 4;
        if (!e || ph < GRD) return 4'hF;
`ifdef SEG_LZ_BLANK_EN
        if (s == 3 && dv[15:12] == 4'h0) return 4'hF;
        if (s == 2 && dv[15:8] == 8'h00) return 4'hF;
        if (s == 1 && dv[15:4] == 12'h000) return 4'hF;
`endif
        case (s)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic run_to(input int target);
        while (k < target) begin
            tick();
            check("S", 32'(S), 32'((k / DIV) % 4));
            check("an", 32'(an), 32'(exp_an(k, exp_d, en)));
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        din  = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_S", 32'(S), 32'h0);
        check("rst_d", 32'({d4, d3, d2, d1}), 32'h0);
        check("rst_pend", 32'(pending), 32'h0);
        check("rst_upd", 32'(upd_done), 32'h0);
        rst = 1'b0;
        run_to(41);

        do_load(16'h1234);
        check("ld_pend", 32'(pending), 32'h1);
        check("ld_d_old", 32'({d4, d3, d2, d1}), 32'h0);
        run_to(63);
        check("pre_upd", 32'(upd_done), 32'h0);
        exp_d = 16'h1234;
        run_to(64);
        check("c_d1", 32'(d1), 32'h4);
        check("c_d2", 32'(d2), 32'h3);
        check("c_d3", 32'(d3), 32'h2);
        check("c_d4", 32'(d4), 32'h1);
        check("c_upd", 32'(upd_done), 32'h1);
        check("c_pend", 32'(pending), 32'h0);
        run_to(65);
        check("c_upd_1cyc", 32'(upd_done), 32'h0);

        run_to(70);
        do_load(16'hAAAA);
        run_to(95);
        check("b_pend", 32'(pending), 32'h1);
        din   = 16'h5555;
        load  = 1'b1;
        exp_d = 16'hAAAA;
        run_to(96);
        load = 1'b0;
        check("b_d1", 32'({d4, d3, d2, d1}), 32'hAAAA);
        check("b_upd1", 32'(upd_done), 32'h1);
        check("b_pend1", 32'(pending), 32'h1);
        run_to(127);
        exp_d = 16'h5555;
        run_to(128);
        check("b_d2", 32'({d4, d3, d2, d1}), 32'h5555);
        check("b_upd2", 32'(upd_done), 32'h1);
        check("b_pend2", 32'(pending), 32'h0);

        run_to(130);
        en = 1'b0;
        run_to(170);
        check("en_off_an", 32'(an), 32'hF);
        en = 1'b1;
        run_to(171);
        check("en_on_an", 32'(an), 32'hD);

        run_to(178);
        check("mr_S", 32'(S), 32'h2);
        do_load(16'h9999);
        check("mr_pend1", 32'(pending), 32'h1);
        rst   = 1'b1;
        exp_d = 16'h0;
        tick();
        check("mr_pend", 32'(pending), 32'h0);
        check("mr_d", 32'({d4, d3, d2, d1}), 32'h0);
        check("mr_an", 32'(an), 32'hF);
        check("mr_S0", 32'(S), 32'h0);
        rst = 1'b0;
        repeat (40) begin
            run_to(k + 1);
            check("mr_upd", 32'(upd_done), 32'h0);
        end
        check("mr_d_end", 32'({d4, d3, d2, d1}), 32'h0);

`ifdef SEG_LZ_BLANK_EN
        do_load(16'h0070);
        run_to(63);
        exp_d = 16'h0070;
        run_to(64);
        check("lz_d", 32'({d4, d3, d2, d1}), 32'h0070);
        while (k < 96) begin
            run_to(k + 1);
            check("lz_an3", 32'(an[3]), 32'h1);
            check("lz_an2", 32'(an[2]), 32'h1);
            if (k == 74) check("lz_an_d2", 32'(an), 32'hD);
            if (k == 66) check("lz_an_d1", 32'(an), 32'hE);
        end
        do_load(16'h0000);
        run_to(127);
        exp_d = 16'h0000;
        run_to(128);
        while (k < 160) begin
            run_to(k + 1);
            check("lz0_an", 32'(an[3:1]), 32'h7);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
